// File: rtl/operand_select_pipe.sv
// Registered operand multiplexer: register file / immediate / ALU result selection feeding a
// one-stage valid/ready pipe with a 2-entry skid buffer. Optional write-back forwarding: OPSEL_FWD_EN.
module operand_select_pipe #(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 8,
    parameter int SEL_W    = 4,
    parameter int CNT_W    = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [SEL_W-1:0]           sel,
    input  logic [DATA_W-1:0]          imm,
    input  logic [NUM_REGS*DATA_W-1:0] regs,
    input  logic [DATA_W-1:0]          alu_r,
`ifdef OPSEL_FWD_EN
    input  logic                       wb_en,
    input  logic [SEL_W-1:0]           wb_addr,
    input  logic [DATA_W-1:0]          wb_data,
`endif
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          out_data,
    output logic                       out_err,
    output logic [CNT_W-1:0]           err_cnt
);

    typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_FULL} state_t;

    localparam logic [SEL_W-1:0] SEL_IMM = SEL_W'(NUM_REGS);
    localparam logic [SEL_W-1:0] SEL_ALU = SEL_W'(NUM_REGS + 1);

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   main_data_q, main_data_d;
    logic                main_err_q, main_err_d;
    logic [DATA_W-1:0]   skid_data_q, skid_data_d;
    logic                skid_err_q, skid_err_d;
    logic [CNT_W-1:0]    err_cnt_q, err_cnt_d;

    logic [DATA_W-1:0]   sel_data;
    logic                sel_err;
    logic                reg_hit;
    logic                accept;
    logic                xfer;

    assign in_ready  = (state_q != ST_FULL);
    assign out_valid = (state_q != ST_EMPTY);
    assign out_data  = main_data_q;
    assign out_err   = main_err_q;
    assign err_cnt   = err_cnt_q;
    assign accept    = in_valid & in_ready;
    assign xfer      = out_valid & out_ready;

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        sel_data = '0;
        sel_err  = 1'b0;
        reg_hit  = 1'b0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (sel == SEL_W'(k)) begin
                sel_data = regs[k*DATA_W +: DATA_W];
                reg_hit  = 1'b1;
            end
        end
`ifdef OPSEL_FWD_EN
        // A write-back landing this cycle is newer than the register file read.
        if (reg_hit && wb_en && (wb_addr == sel)) begin
            sel_data = wb_data;
        end
`endif
        if (sel == SEL_IMM) begin
            sel_data = imm;
        end else if (sel == SEL_ALU) begin
            sel_data = alu_r;
        end else if (!reg_hit) begin
            sel_err = 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        main_err_d  = main_err_q;
        skid_data_d = skid_data_q;
        skid_err_d  = skid_err_q;
        err_cnt_d   = err_cnt_q;

        if (accept && sel_err && !(&err_cnt_q)) begin
            err_cnt_d = err_cnt_q + CNT_W'(1);
        end

        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    main_data_d = sel_data;
                    main_err_d  = sel_err;
                    state_d     = ST_ONE;
                end
            end
            ST_ONE: begin
                if (accept && xfer) begin
                    main_data_d = sel_data;
                    main_err_d  = sel_err;
                end else if (accept) begin
                    skid_data_d = sel_data;
                    skid_err_d  = sel_err;
                    state_d     = ST_FULL;
                end else if (xfer) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (xfer) begin
                    main_data_d = skid_data_q;
                    main_err_d  = skid_err_q;
                    state_d     = ST_ONE;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    // NOTE: state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_EMPTY;
            main_data_q <= '0;
            main_err_q  <= 1'b0;
            skid_data_q <= '0;
            skid_err_q  <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            main_data_q <= main_data_d;
            main_err_q  <= main_err_d;
            skid_data_q <= skid_data_d;
            skid_err_q  <= skid_err_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

endmodule

// File: tb/tb_operand_select_pipe.sv
// Self-checking bench for operand_select_pipe: directed steps plus a random handshake run,
// with a scoreboard queue filled on accept and drained on output transfer.
module tb_operand_select_pipe;

    localparam int DATA_W   = 16;
    localparam int NUM_REGS = 8;
    localparam int SEL_W    = 4;
    localparam int CNT_W    = 8;

    logic                       clk = 1'b0;
    logic                       rst_n;
    logic                       in_valid;
    logic                       in_ready;
    logic [SEL_W-1:0]           sel;
    logic [DATA_W-1:0]          imm;
    logic [NUM_REGS*DATA_W-1:0] regs;
    logic [DATA_W-1:0]          alu_r;
`ifdef OPSEL_FWD_EN
    logic                       wb_en;
    logic [SEL_W-1:0]           wb_addr;
    logic [DATA_W-1:0]          wb_data;
`endif
    logic                       out_valid;
    logic                       out_ready;
    logic [DATA_W-1:0]          out_data;
    logic                       out_err;
    logic [CNT_W-1:0]           err_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    logic [DATA_W:0] sb[$];
    logic            stall_seen = 1'b0;
    logic [DATA_W:0] held;

    operand_select_pipe #(
        .DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .SEL_W(SEL_W), .CNT_W(CNT_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .sel      (sel),
        .imm      (imm),
        .regs     (regs),
        .alu_r    (alu_r),
`ifdef OPSEL_FWD_EN
        .wb_en    (wb_en),
        .wb_addr  (wb_addr),
        .wb_data  (wb_data),
`endif
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_err  (out_err),
        .err_cnt  (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference result {err, data} for the inputs currently presented.
    function automatic logic [DATA_W:0] model();
        logic [DATA_W-1:0] d;
        if (sel < NUM_REGS) begin
            d = regs[int'(sel)*DATA_W +: DATA_W];
`ifdef OPSEL_FWD_EN
            if (wb_en && wb_addr == sel) d = wb_data;
`endif
            return {1'b0, d};
        end
        if (sel == NUM_REGS)     return {1'b0, imm};
        if (sel == NUM_REGS + 1) return {1'b0, alu_r};
        return {1'b1, {DATA_W{1'b0}}};
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
            stall_seen = 1'b0;
        end else begin
            if (stall_seen && out_valid) begin
                check("stall_data", 32'(out_data), 32'(held[DATA_W-1:0]));
                check("stall_err", 32'(out_err), 32'(held[DATA_W]));
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("sb_unexpected_output", 32'(1), 32'(0));
                end else begin
                    logic [DATA_W:0] e;
                    e = sb.pop_front();
                    check("sb_data", 32'(out_data), 32'(e[DATA_W-1:0]));
                    check("sb_err", 32'(out_err), 32'(e[DATA_W]));
                end
            end
            if (in_valid && in_ready) sb.push_back(model());
            stall_seen = out_valid && !out_ready;
            held       = {out_err, out_data};
        end
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        sel       = '0;
        imm       = '0;
        regs      = '0;
        alu_r     = '0;
`ifdef OPSEL_FWD_EN
        wb_en     = 1'b0;
        wb_addr   = '0;
        wb_data   = '0;
`endif
        #2;
        check("rst_out_valid", 32'(out_valid), 32'(0));
        check("rst_out_data", 32'(out_data), 32'(0));
        check("rst_err_cnt", 32'(err_cnt), 32'(0));
        step();
        rst_n = 1'b1;
        step();
        check("rst_in_ready", 32'(in_ready), 32'(1));

        // Register source, one-cycle latency.
        regs[3*DATA_W +: DATA_W] = 16'h1234;
        sel       = 4'd3;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        check("reg3_valid", 32'(out_valid), 32'(1));
        check("reg3_data", 32'(out_data), 32'h1234);
        check("reg3_err", 32'(out_err), 32'(0));
        step();
        check("reg3_drained", 32'(out_valid), 32'(0));

        // Immediate then ALU result while the consumer stalls: fills the skid.
        out_ready = 1'b0;
        sel       = 4'd8;
        imm       = 16'h00FF;
        in_valid  = 1'b1;
        step();
        sel   = 4'd9;
        alu_r = 16'hBEEF;
        step();
        in_valid = 1'b0;
        imm      = 16'h5555;
        alu_r    = 16'h6666;
        step();
        check("full_in_ready", 32'(in_ready), 32'(0));
        check("full_out_data", 32'(out_data), 32'h00FF);
        sel      = 4'd3;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check("full_hold_data", 32'(out_data), 32'h00FF);
        check("full_hold_ready", 32'(in_ready), 32'(0));
        out_ready = 1'b1;
        step();
        check("skid_to_main", 32'(out_data), 32'hBEEF);
        step();
        check("full_drained", 32'(out_valid), 32'(0));
        check("full_ready_back", 32'(in_ready), 32'(1));

        // Illegal select and counter saturation.
        sel      = 4'hF;
        in_valid = 1'b1;
        step();
        check("illegal_data", 32'(out_data), 32'(0));
        check("illegal_err", 32'(out_err), 32'(1));
        check("illegal_cnt1", 32'(err_cnt), 32'(1));
        repeat (299) step();
        in_valid = 1'b0;
        step();
        check("illegal_cnt_sat", 32'(err_cnt), 32'hFF);

`ifdef OPSEL_FWD_EN
        regs[2*DATA_W +: DATA_W] = 16'h0001;
        sel      = 4'd2;
        wb_en    = 1'b1;
        wb_addr  = 4'd2;
        wb_data  = 16'hAAAA;
        in_valid = 1'b1;
        step();
        check("fwd_hit", 32'(out_data), 32'hAAAA);
        wb_addr = 4'd5;
        step();
        in_valid = 1'b0;
        wb_en    = 1'b0;
        check("fwd_miss", 32'(out_data), 32'h0001);
        step();
`endif

        // Random handshake traffic; a stalled request is held until accepted.
        for (int c = 0; c < 10000; c++) begin
            if (!(in_valid && !in_ready)) begin
                in_valid = 1'($urandom_range(0, 1));
                sel      = SEL_W'($urandom_range(0, 15));
                imm      = DATA_W'($urandom);
                alu_r    = DATA_W'($urandom);
                regs     = {$urandom, $urandom, $urandom, $urandom};
`ifdef OPSEL_FWD_EN
                wb_en    = 1'($urandom_range(0, 1));
                wb_addr  = SEL_W'($urandom_range(0, 15));
                wb_data  = DATA_W'($urandom);
`endif
            end
            out_ready = 1'($urandom_range(0, 3) != 0);
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (4) step();
        check("random_sb_empty", 32'(sb.size()), 32'(0));

        // Reset while FULL drops everything in flight.
        out_ready = 1'b0;
        sel       = 4'd1;
        in_valid  = 1'b1;
        step();
        sel = 4'd8;
        step();
        in_valid = 1'b0;
        check("pre_rst_full", 32'(in_ready), 32'(0));
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 32'(0));
        check("mid_rst_err_cnt", 32'(err_cnt), 32'(0));
        check("mid_rst_out_data", 32'(out_data), 32'(0));
        step();
        rst_n = 1'b1;
        step();
        check("post_rst_in_ready", 32'(in_ready), 32'(1));
        out_ready = 1'b1;
        repeat (2) step();
        check("post_rst_no_data", 32'(out_valid), 32'(0));
        check("post_rst_sb_empty", 32'(sb.size()), 32'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
